// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    localparam int          ETH_ADDR_BYTES = 6;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // Byte idx of a MAC address in wire order (byte 0 is the most significant).
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
        case (idx)
            3'd0:    addr_byte = addr[47:40];
            3'd1:    addr_byte = addr[39:32];
            3'd2:    addr_byte = addr[31:24];
            3'd3:    addr_byte = addr[23:16];
            3'd4:    addr_byte = addr[15:8];
            3'd5:    addr_byte = addr[7:0];
            default: addr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_mem.sv
// Simple dual-port frame storage: one write port, one synchronous read port, 9-bit words.
module eth_rx_frame_fifo_mem
    import eth_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [8:0]    rdata
);

    logic [8:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer; bad, runt, overflowing frames are rewound away.
// Optional destination address filter is built when ETH_RX_MAC_FILTER_EN is defined.
module eth_rx_frame_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic [47:0]           local_mac_i,
    input  logic                  promisc_i,
    output logic                  drop_bad_o,
    output logic                  drop_ovf_o,
    output logic                  drop_filt_o,
    output logic [DEPTH_LOG2:0]   frames_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_VAL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    wr_state_t             state_reg, state_next;
    logic [DEPTH_LOG2:0]   wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0]   wr_commit_reg, wr_commit_next;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic [2:0]            cnt_reg, cnt_next;
    logic                  drop_bad_reg, drop_bad_next;
    logic                  drop_ovf_reg, drop_ovf_next;
    logic                  drop_filt_reg, drop_filt_next;
    logic [DEPTH_LOG2:0]   frames_reg;
    logic                  mem_we, commit, full, filt_miss;
    logic [8:0]            mem_wdata, mem_rdata;
    logic [2:0]            idx;

    logic                  rd_pend_reg, issue, pop;
    logic [1:0]            skid_cnt_reg, occ;
    logic [8:0]            skid0_reg, skid1_reg;

    assign full = (wr_ptr_reg - rd_ptr_reg) == DEPTH_VAL;
    assign idx  = (state_reg == IDLE) ? 3'd0 : cnt_reg;

`ifdef ETH_RX_MAC_FILTER_EN
    logic uc_reg, uc_next, bc_reg, bc_next, mc_reg, mc_next, in_addr;

    // Match flags include the current byte so a 6-byte frame is judged on its last beat.
    always_comb begin
        in_addr   = idx < 3'(ETH_ADDR_BYTES);
        uc_next   = ((idx == 3'd0) ? 1'b1 : uc_reg) &
                    (!in_addr || s_axis_tdata == addr_byte(local_mac_i, idx));
        bc_next   = ((idx == 3'd0) ? 1'b1 : bc_reg) &
                    (!in_addr || s_axis_tdata == addr_byte(ETH_BCAST_ADDR, idx));
        mc_next   = (idx == 3'd0) ? s_axis_tdata[0] : mc_reg;
        filt_miss = !(promisc_i || uc_next || bc_next || mc_next);
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            uc_reg <= 1'b0;
            bc_reg <= 1'b0;
            mc_reg <= 1'b0;
        end else if (s_axis_tvalid && state_reg != DROP) begin
            uc_reg <= uc_next;
            bc_reg <= bc_next;
            mc_reg <= mc_next;
        end
    end
`else
    logic unused_filter;
    assign unused_filter = ^{local_mac_i, promisc_i};
    assign filt_miss     = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        wr_commit_next = wr_commit_reg;
        cnt_next       = cnt_reg;
        mem_we         = 1'b0;
        mem_wdata      = {1'b0, s_axis_tdata};
        commit         = 1'b0;
        drop_bad_next  = 1'b0;
        drop_ovf_next  = 1'b0;
        drop_filt_next = 1'b0;
        case (state_reg)
            IDLE, RECV: begin
                if (s_axis_tvalid) begin
                    cnt_next = (idx == 3'd6) ? 3'd6 : idx + 3'd1;
                    if (s_axis_tlast) begin
                        state_next  = IDLE;
                        wr_ptr_next = wr_commit_reg;
                        if (full) begin
                            drop_ovf_next = 1'b1;
                        end else if (idx < 3'd5 || s_axis_tuser) begin
                            drop_bad_next = 1'b1;
                        end else if (filt_miss) begin
                            drop_filt_next = 1'b1;
                        end else begin
                            mem_we         = 1'b1;
                            mem_wdata      = {1'b1, s_axis_tdata};
                            wr_ptr_next    = wr_ptr_reg + PTR_ONE;
                            wr_commit_next = wr_ptr_reg + PTR_ONE;
                            commit         = 1'b1;
                        end
                    end else if (full) begin
                        state_next  = DROP;
                        wr_ptr_next = wr_commit_reg;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PTR_ONE;
                        state_next  = RECV;
                    end
                end
            end
            DROP: begin
                // DROP is only ever entered on overflow.
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_ovf_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            wr_commit_reg <= '0;
            cnt_reg       <= 3'd0;
            drop_bad_reg  <= 1'b0;
            drop_ovf_reg  <= 1'b0;
            drop_filt_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            wr_commit_reg <= wr_commit_next;
            cnt_reg       <= cnt_next;
            drop_bad_reg  <= drop_bad_next;
            drop_ovf_reg  <= drop_ovf_next;
            drop_filt_reg <= drop_filt_next;
        end
    end

    eth_rx_frame_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
        .clk   (rx_clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wdata (mem_wdata),
        .re    (issue),
        .raddr (rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rdata (mem_rdata)
    );

    // A read is issued only if the skid stage can hold it counting the beat in flight.
    assign pop   = (skid_cnt_reg != 2'd0) && m_axis_tready;
    assign occ   = 2'(skid_cnt_reg + 2'(rd_pend_reg) - 2'(pop));
    assign issue = (rd_ptr_reg != wr_commit_reg) && (occ < 2'd2);

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            rd_ptr_reg   <= '0;
            rd_pend_reg  <= 1'b0;
            skid_cnt_reg <= 2'd0;
            skid0_reg    <= 9'd0;
            skid1_reg    <= 9'd0;
        end else begin
            rd_pend_reg <= issue;
            if (issue) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({rd_pend_reg, pop})
                2'b11: begin
                    if (skid_cnt_reg == 2'd2) begin
                        skid0_reg <= skid1_reg;
                        skid1_reg <= mem_rdata;
                    end else begin
                        skid0_reg <= mem_rdata;
                    end
                end
                2'b10: begin
                    if (skid_cnt_reg == 2'd0) begin
                        skid0_reg <= mem_rdata;
                    end else begin
                        skid1_reg <= mem_rdata;
                    end
                    skid_cnt_reg <= skid_cnt_reg + 2'd1;
                end
                2'b01: begin
                    skid0_reg    <= skid1_reg;
                    skid_cnt_reg <= skid_cnt_reg - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            frames_reg <= '0;
        end else begin
            case ({commit, pop && skid0_reg[8]})
                2'b10:   frames_reg <= frames_reg + PTR_ONE;
                2'b01:   frames_reg <= frames_reg - PTR_ONE;
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = skid_cnt_reg != 2'd0;
    assign m_axis_tdata  = skid0_reg[7:0];
    assign m_axis_tlast  = skid0_reg[8];
    assign drop_bad_o    = drop_bad_reg;
    assign drop_ovf_o    = drop_ovf_reg;
    assign drop_filt_o   = drop_filt_reg;
    assign frames_o      = frames_reg;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: stimulus queues expected beats/drops, monitor checks them.
module tb_eth_rx_frame_fifo;

    localparam int DL = 6;
    localparam logic [47:0] LOCAL_MAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST_MAC = 48'h01_00_5E_00_00_01;
    localparam logic [2:0]  D_NONE = 3'b000, D_BAD = 3'b001, D_OVF = 3'b010, D_FILT = 3'b100;
`ifdef ETH_RX_MAC_FILTER_EN
    localparam logic [2:0]  FILT_EXP = D_FILT;
`else
    localparam logic [2:0]  FILT_EXP = D_NONE;
`endif

    logic          rx_clk = 1'b0;
    logic          rx_rst_n;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          promisc;
    logic          drop_bad_o, drop_ovf_o, drop_filt_o;
    logic [DL:0]   frames_o;

    logic [8:0]    exp_q[$];
    logic [2:0]    drop_q[$];
    int            tests = 0;
    int            fails = 0;
    int            ready_mode = 0;

    always #5 rx_clk = ~rx_clk;

    eth_rx_frame_fifo #(.DEPTH_LOG2(DL)) dut (
        .rx_clk        (rx_clk),
        .rx_rst_n      (rx_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .local_mac_i   (LOCAL_MAC),
        .promisc_i     (promisc),
        .drop_bad_o    (drop_bad_o),
        .drop_ovf_o    (drop_ovf_o),
        .drop_filt_o   (drop_filt_o),
        .frames_o      (frames_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic ready_driver();
        m_axis_tready = 1'b0;
        forever begin
            @(posedge rx_clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic monitor();
        logic       prev_stall = 1'b0;
        logic [8:0] prev_beat = 9'd0;
        logic [8:0] e;
        logic [2:0] d, de;
        forever begin
            @(negedge rx_clk);
            if (!rx_rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    tests++;
                    if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_beat) begin
                        fails++;
                        $display("[TB] FAIL axi_hold: got v=%0b %0h expected v=1 %0h",
                                 m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_beat);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL beat: got %0h expected no beat", {m_axis_tlast, m_axis_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        if (e != {m_axis_tlast, m_axis_tdata}) begin
                            fails++;
                            $display("[TB] FAIL beat: got %0h expected %0h", {m_axis_tlast, m_axis_tdata}, e);
                        end
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
                d = {drop_filt_o, drop_ovf_o, drop_bad_o};
                if (d != 3'b000) begin
                    tests++;
                    de = (drop_q.size() != 0) ? drop_q.pop_front() : 3'b000;
                    if (d != de) begin
                        fails++;
                        $display("[TB] FAIL drop: got %03b expected %03b", d, de);
                    end else begin
                        $display("[TB] ok drop %03b", d);
                    end
                end
            end
        end
    endtask

    // Drives one frame; a committed frame's beats go to the scoreboard, else its drop code.
    task automatic send_frame(input int len, input logic bad, input logic [47:0] dst,
                              input logic [7:0] seed, input logic [2:0] exp_drop, input int gap);
        logic [7:0] b;
        if (exp_drop != D_NONE) drop_q.push_back(exp_drop);
        for (int i = 0; i < len; i++) begin
            if (i < 6) b = 8'(dst >> (40 - 8 * i));
            else       b = seed + 8'(i);
            if (exp_drop == D_NONE) exp_q.push_back({(i == len - 1), b});
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = bad && (i == len - 1);
            tick(1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        tick(gap + 1);
        $display("[TB] frame len=%0d bad=%0b dst=%012h drop=%03b", len, bad, dst, exp_drop);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || drop_q.size() != 0 || m_axis_tvalid) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_drained"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        fork
            ready_driver();
            monitor();
        join_none
        rx_rst_n      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'd0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        promisc       = 1'b0;
        tick(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_drops", 32'({drop_bad_o, drop_ovf_o, drop_filt_o}), 32'd0);
        check("rst_frames", 32'(frames_o), 32'd0);
        rx_rst_n = 1'b1;
        tick(2);

        // 64-byte good frame fills the 64-entry buffer exactly
        ready_mode = 0;
        send_frame(64, 1'b0, LOCAL_MAC, 8'h10, D_NONE, 2);
        check("frames_one", 32'(frames_o), 32'd1);
        ready_mode = 1;
        wait_idle("good64", 200);
        check("frames_zero", 32'(frames_o), 32'd0);

        send_frame(64, 1'b1, LOCAL_MAC, 8'h20, D_BAD, 2);
        send_frame(20, 1'b0, BCAST_MAC, 8'h30, D_NONE, 2);
        wait_idle("bad_then_good", 200);

        // Second 40-byte frame cannot fit behind the first
        ready_mode = 0;
        send_frame(40, 1'b0, LOCAL_MAC, 8'h40, D_NONE, 2);
        send_frame(40, 1'b0, LOCAL_MAC, 8'h50, D_OVF, 2);
        check("ovf_frames", 32'(frames_o), 32'd1);
        ready_mode = 1;
        wait_idle("ovf", 200);
        check("ovf_frames_zero", 32'(frames_o), 32'd0);

        // Runt boundaries
        send_frame(4, 1'b0, LOCAL_MAC, 8'h60, D_BAD, 2);
        check("runt_ptr", 32'(dut.wr_ptr_reg == dut.wr_commit_reg), 32'd1);
        send_frame(1, 1'b0, LOCAL_MAC, 8'h61, D_BAD, 2);
        send_frame(5, 1'b0, LOCAL_MAC, 8'h62, D_BAD, 2);
        send_frame(6, 1'b0, LOCAL_MAC, 8'h63, D_NONE, 2);
        wait_idle("runts", 100);
        check("runt_frames", 32'(frames_o), 32'd0);

        // Address filter
        send_frame(12, 1'b0, OTHER_MAC, 8'h70, FILT_EXP, 2);
        send_frame(12, 1'b0, BCAST_MAC, 8'h71, D_NONE, 2);
        send_frame(12, 1'b0, MCAST_MAC, 8'h72, D_NONE, 2);
        promisc = 1'b1;
        send_frame(12, 1'b0, OTHER_MAC, 8'h70, D_NONE, 2);
        promisc = 1'b0;
        wait_idle("filter", 100);

        // Random backpressure, many frames, pointer wrap
        ready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            send_frame(6 + (i % 10), (i % 7) == 3, LOCAL_MAC, 8'(i * 3),
                       ((i % 7) == 3) ? D_BAD : D_NONE, 10 + (i % 10));
        end
        wait_idle("random", 2000);
        check("random_frames", 32'(frames_o), 32'd0);

        // Reset with a buffered frame and a frame partly received
        ready_mode = 0;
        send_frame(10, 1'b0, LOCAL_MAC, 8'h80, D_NONE, 2);
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(8'h90 + i);
            tick(1);
        end
        rx_rst_n      = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        tick(2);
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_frames", 32'(frames_o), 32'd0);
        rx_rst_n = 1'b1;
        tick(2);
        ready_mode = 1;
        send_frame(8, 1'b0, LOCAL_MAC, 8'hA0, D_NONE, 2);
        wait_idle("post_rst", 100);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("drop_q_empty", 32'(drop_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
